phase_sequencer: RTL and testbench

Parametrised, sensor-actuated phase sequencer for the intersection controller: it replaces the fixed-intersection light FSM and its separate seconds timer with one block. The block steps through NUM_PHASES signal phases with green, yellow and all-red clearance intervals. It adds skip-on-no-demand, green extension under demand, and a flashing fault mode. Its per-light 2-bit codes drive the existing semaforo3/semaforo2 driver instances directly.

---
 rtl/phase_sequencer.sv | 229 ++++++++++++++++++++++
 tb/tb_phase_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// ============================================================================
//  Module      : phase_sequencer
//  Description : Sensor-actuated N-phase traffic sequencer with green,
//                yellow and all-red clearance intervals, skip-on-no-demand,
//                green extension under demand and a flashing fault mode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_sequencer #(
    parameter int                               NUM_PHASES    = 3,
    parameter int                               NUM_LIGHTS    = 9,
    parameter int                               CLK_HZ        = 10000,
    parameter int                               TIME_W        = 16,
    parameter int                               GREEN_SEC     = 20,
    parameter int                               MAX_GREEN_SEC = 40,
    parameter int                               YELLOW_SEC    = 3,
    parameter int                               CLEAR_SEC     = 2,
    parameter logic [NUM_PHASES*NUM_LIGHTS-1:0] PHASE_MASK    = {9'h1C0, 9'h038, 9'h007},
    parameter logic [NUM_LIGHTS-1:0]            PED_MASK      = '0,
    parameter bit                               SKIP_EN       = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          flash,
    input  logic [NUM_PHASES-1:0]         demand,
    output logic [2*NUM_LIGHTS-1:0]       lights,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic [2:0]                    state,
    output logic [TIME_W-1:0]             sec_elapsed,
    output logic                          phase_start
);

    localparam int PHASE_W = $clog2(NUM_PHASES);
    localparam int PRESC_W = $clog2(CLK_HZ + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

    localparam logic [2:0] ST_CLEAR  = 3'd0;
    localparam logic [2:0] ST_GREEN  = 3'd1;
    localparam logic [2:0] ST_YELLOW = 3'd2;
    localparam logic [2:0] ST_FLASH  = 3'd3;

    localparam logic [1:0] LT_RED    = 2'b00;
    localparam logic [1:0] LT_YELLOW = 2'b01;
    localparam logic [1:0] LT_GREEN  = 2'b10;
    localparam logic [1:0] LT_DARK   = 2'b11;

    // Reject impossible configurations at elaboration time.
    generate
        if (NUM_PHASES < 2 || NUM_PHASES > 8 || NUM_LIGHTS < 1 || CLK_HZ < 1 ||
            GREEN_SEC < 1 || MAX_GREEN_SEC < GREEN_SEC || YELLOW_SEC < 1 ||
            CLEAR_SEC < 1) begin : g_param_check
            $error("phase_sequencer: illegal phase count or interval duration");
        end
    endgenerate

    logic [NUM_PHASES-1:0]   r_sync1;
    logic [NUM_PHASES-1:0]   r_sync2;
    logic [NUM_PHASES-1:0]   r_req;
    logic [NUM_PHASES-1:0]   w_req_next;
    logic [NUM_PHASES-1:0]   w_req_clear;
    logic [PRESC_W-1:0]      r_presc;
    logic [PRESC_W-1:0]      w_presc_next;
    logic [TIME_W-1:0]       w_sec_inc;
    logic [TIME_W-1:0]       w_sec_next;
    logic                    r_flash_on;
    logic                    w_flash_on_next;
    logic                    w_run;
    logic                    w_tick;
    logic                    w_change;
    logic                    w_dem_cur;
    logic                    w_found;
    logic [2:0]              w_state_next;
    logic [PHASE_W-1:0]      w_phase_next;
    logic [PHASE_W-1:0]      w_phase_succ;
    logic [PHASE_W-1:0]      w_phase_pick;
    logic [NUM_LIGHTS-1:0]   w_green_mask;
    logic [2*NUM_LIGHTS-1:0] w_lights_next;
    logic                    w_phase_start_next;

    // Timing runs while enabled; flash mode keeps its own timing regardless.
    assign w_run     = enable || (state == ST_FLASH);
    assign w_tick    = w_run && (r_presc == PRESC_LAST);
    assign w_sec_inc = (&sec_elapsed) ? sec_elapsed : sec_elapsed + TIME_W'(1);
    assign w_dem_cur = r_sync2[phase];

    // Next phase: first latched request after the current phase, else successor.
    always_comb begin
        w_phase_succ = (int'(phase) == NUM_PHASES - 1) ? '0 : phase + PHASE_W'(1);
        w_phase_pick = w_phase_succ;
        w_found      = 1'b0;
        for (int k = 1; k <= NUM_PHASES; k++) begin
            if (!w_found && r_req[(int'(phase) + k) % NUM_PHASES]) begin
                w_phase_pick = PHASE_W'((int'(phase) + k) % NUM_PHASES);
                w_found      = 1'b1;
            end
        end
        if (!SKIP_EN) begin
            w_phase_pick = w_phase_succ;
        end
    end

    // Next-state logic: interval sequencing, flash entry/exit and timers.
    always_comb begin
        w_state_next    = state;
        w_phase_next    = phase;
        w_flash_on_next = r_flash_on;
        w_change        = 1'b0;
        if (flash && state != ST_FLASH) begin
            w_state_next    = ST_FLASH;
            w_flash_on_next = 1'b1;
            w_change        = 1'b1;
        end else if (state == ST_FLASH) begin
            if (!flash) begin
                w_state_next = ST_CLEAR;
                w_change     = 1'b1;
            end else if (w_tick) begin
                w_flash_on_next = ~r_flash_on;
            end
        end else if (enable) begin
            case (state)
                ST_CLEAR: begin
                    if (w_tick && w_sec_inc == TIME_W'(CLEAR_SEC)) begin
                        w_state_next = ST_GREEN;
                        w_phase_next = w_phase_pick;
                        w_change     = 1'b1;
                    end
                end
                ST_GREEN: begin
                    // Gap-out once minimum green is served; max-out is unconditional.
                    if (w_tick && w_sec_inc >= TIME_W'(GREEN_SEC) &&
                        (!w_dem_cur || w_sec_inc >= TIME_W'(MAX_GREEN_SEC))) begin
                        w_state_next = ST_YELLOW;
                        w_change     = 1'b1;
                    end
                end
                ST_YELLOW: begin
                    if (w_tick && w_sec_inc == TIME_W'(YELLOW_SEC)) begin
                        w_state_next = ST_CLEAR;
                        w_change     = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_CLEAR;
                    w_change     = 1'b1;
                end
            endcase
        end

        w_presc_next = r_presc;
        w_sec_next   = sec_elapsed;
        if (w_change) begin
            w_presc_next = '0;
            w_sec_next   = '0;
        end else if (w_run) begin
            w_presc_next = w_tick ? '0 : r_presc + PRESC_W'(1);
            w_sec_next   = w_tick ? w_sec_inc : sec_elapsed;
        end

        w_phase_start_next = (w_state_next == ST_GREEN) && (state != ST_GREEN);

        // Entering GREEN for a phase consumes its request; a same-cycle set loses.
        w_req_clear = '0;
        if (w_phase_start_next) begin
            w_req_clear[w_phase_next] = 1'b1;
        end
        w_req_next = (r_req | r_sync2) & ~w_req_clear;
    end

    // Output decode: light aspects for the upcoming state, registered below.
    always_comb begin
        w_green_mask  = NUM_LIGHTS'(PHASE_MASK >> (int'(w_phase_next) * NUM_LIGHTS));
        w_lights_next = '0;
        for (int l = 0; l < NUM_LIGHTS; l++) begin
            case (w_state_next)
                ST_GREEN: begin
                    w_lights_next[2*l +: 2] = w_green_mask[l] ? LT_GREEN : LT_RED;
                end
                ST_YELLOW: begin
                    w_lights_next[2*l +: 2] = (w_green_mask[l] && !PED_MASK[l]) ? LT_YELLOW : LT_RED;
                end
                ST_FLASH: begin
                    if (r_flash_on == 1'b0 && w_flash_on_next == 1'b0) begin
                        w_lights_next[2*l +: 2] = LT_DARK;
                    end else if (w_flash_on_next) begin
                        w_lights_next[2*l +: 2] = PED_MASK[l] ? LT_RED : LT_YELLOW;
                    end else begin
                        w_lights_next[2*l +: 2] = LT_DARK;
                    end
                end
                default: begin
                    w_lights_next[2*l +: 2] = LT_RED;
                end
            endcase
        end
    end

    // State register: synchronizers, requests, timers, state and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_req       <= '0;
            r_presc     <= '0;
            r_flash_on  <= 1'b0;
            sec_elapsed <= '0;
            state       <= ST_CLEAR;
            phase       <= PHASE_W'(NUM_PHASES - 1);
            lights      <= '0;
            phase_start <= 1'b0;
        end else begin
            r_sync1     <= demand;
            r_sync2     <= r_sync1;
            r_req       <= w_req_next;
            r_presc     <= w_presc_next;
            r_flash_on  <= w_flash_on_next;
            sec_elapsed <= w_sec_next;
            state       <= w_state_next;
            phase       <= w_phase_next;
            lights      <= w_lights_next;
            phase_start <= w_phase_start_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_phase_sequencer.sv
// ============================================================================
//  Module      : tb_phase_sequencer
//  Description : Directed self-checking bench for phase_sequencer using two
//                instances: A (SKIP_EN=0) and B (SKIP_EN=1, light 0 two-aspect).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_phase_sequencer;

    localparam logic [17:0] L_RED   = 18'h00000;
    localparam logic [17:0] L_G0    = 18'h0002A;
    localparam logic [17:0] L_G1    = 18'h00A80;
    localparam logic [17:0] L_G2    = 18'h2A000;
    localparam logic [17:0] L_Y0    = 18'h00015;
    localparam logic [17:0] L_Y0PED = 18'h00014;
    localparam logic [17:0] L_Y2    = 18'h15000;
    localparam logic [17:0] L_FON   = 18'h15555;
    localparam logic [17:0] L_FOFF  = 18'h3FFFF;

    logic        clk = 1'b0;
    logic        reset_a, enable_a, flash_a;
    logic [2:0]  demand_a;
    logic [17:0] lights_a;
    logic [1:0]  phase_a;
    logic [2:0]  state_a;
    logic [15:0] sec_a;
    logic        pstart_a;

    logic        reset_b, enable_b, flash_b;
    logic [2:0]  demand_b;
    logic [17:0] lights_b;
    logic [1:0]  phase_b;
    logic [2:0]  state_b;
    logic [15:0] sec_b;
    logic        pstart_b;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    phase_sequencer #(
        .NUM_PHASES(3), .NUM_LIGHTS(9), .CLK_HZ(10), .TIME_W(16),
        .GREEN_SEC(2), .MAX_GREEN_SEC(4), .YELLOW_SEC(1), .CLEAR_SEC(1),
        .PED_MASK(9'h000), .SKIP_EN(1'b0)
    ) u_dut_a (
        .clk(clk), .reset(reset_a), .enable(enable_a), .flash(flash_a),
        .demand(demand_a), .lights(lights_a), .phase(phase_a), .state(state_a),
        .sec_elapsed(sec_a), .phase_start(pstart_a)
    );

    phase_sequencer #(
        .NUM_PHASES(3), .NUM_LIGHTS(9), .CLK_HZ(10), .TIME_W(16),
        .GREEN_SEC(2), .MAX_GREEN_SEC(4), .YELLOW_SEC(1), .CLEAR_SEC(1),
        .PED_MASK(9'h001), .SKIP_EN(1'b1)
    ) u_dut_b (
        .clk(clk), .reset(reset_b), .enable(enable_b), .flash(flash_b),
        .demand(demand_b), .lights(lights_b), .phase(phase_b), .state(state_b),
        .sec_elapsed(sec_b), .phase_start(pstart_b)
    );

    function automatic logic [22:0] sig(input bit which);
        return which ? {state_b, phase_b, lights_b} : {state_a, phase_a, lights_a};
    endfunction

    // Count consecutive sampled cycles with unchanged state/phase/lights.
    task automatic measure(input bit which, input int start, output int n);
        logic [22:0] s0;
        s0 = sig(which);
        n  = start;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sig(which) != s0) break;
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        reset_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++; if (state_a !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_a); else passed++;
        total++; if (phase_a !== 2'd2) $display("FAIL reset_phase: got %0d want 2", phase_a); else passed++;
        total++; if (lights_a !== L_RED) $display("FAIL reset_lights: got %h want %h", lights_a, L_RED); else passed++;
        total++; if (sec_a !== 16'd0) $display("FAIL reset_sec: got %0d want 0", sec_a); else passed++;
        total++; if (pstart_a !== 1'b0) $display("FAIL reset_pstart: got %b want 0", pstart_a); else passed++;
        reset_a = 1'b0;
        measure(1'b0, 1, n);
        total++; if (n !== 10) $display("FAIL reset_clear_len: got %0d want 10", n); else passed++;
        total++; if (pstart_a !== 1'b1) $display("FAIL pstart_first: got %b want 1", pstart_a); else passed++;
        @(negedge clk);
        total++; if (pstart_a !== 1'b0) $display("FAIL pstart_second: got %b want 0", pstart_a); else passed++;
    endtask

    task automatic test_basic_cycle();
        int n;
        total++; if (lights_a !== L_G0 || phase_a !== 2'd0) $display("FAIL g0_lights: got %h/%0d want %h/0", lights_a, phase_a, L_G0); else passed++;
        measure(1'b0, 2, n);
        total++; if (n !== 20) $display("FAIL g0_len: got %0d want 20", n); else passed++;
        total++; if (state_a !== 3'd2 || lights_a !== L_Y0) $display("FAIL y0: got %0d/%h want 2/%h", state_a, lights_a, L_Y0); else passed++;
        measure(1'b0, 1, n);
        total++; if (n !== 10) $display("FAIL y0_len: got %0d want 10", n); else passed++;
        total++; if (state_a !== 3'd0 || lights_a !== L_RED) $display("FAIL c0: got %0d/%h want 0/%h", state_a, lights_a, L_RED); else passed++;
        measure(1'b0, 1, n);
        total++; if (n !== 10) $display("FAIL c0_len: got %0d want 10", n); else passed++;
        total++; if (phase_a !== 2'd1 || lights_a !== L_G1) $display("FAIL g1: got %0d/%h want 1/%h", phase_a, lights_a, L_G1); else passed++;
        measure(1'b0, 1, n);
        measure(1'b0, 1, n);
        measure(1'b0, 1, n);
        total++; if (phase_a !== 2'd2 || lights_a !== L_G2) $display("FAIL g2: got %0d/%h want 2/%h", phase_a, lights_a, L_G2); else passed++;
        measure(1'b0, 1, n);
        measure(1'b0, 1, n);
        measure(1'b0, 1, n);
        total++; if (phase_a !== 2'd0 || state_a !== 3'd1) $display("FAIL wrap: got %0d/%0d want 0/1", phase_a, state_a); else passed++;
    endtask

    task automatic test_extension();
        int n;
        demand_a = 3'b001;
        measure(1'b0, 1, n);
        total++; if (n !== 40) $display("FAIL ext_max_len: got %0d want 40", n); else passed++;
        for (int i = 0; i < 8; i++) measure(1'b0, 1, n);
        total++; if (phase_a !== 2'd0 || state_a !== 3'd1) $display("FAIL ext_back_g0: got %0d/%0d want 0/1", phase_a, state_a); else passed++;
        n = 1;
        repeat (24) begin
            @(negedge clk);
            n++;
        end
        total++; if (sec_a !== 16'd2) $display("FAIL ext_sec25: got %0d want 2", sec_a); else passed++;
        demand_a = 3'b000;
        measure(1'b0, n, n);
        total++; if (n !== 30) $display("FAIL ext_gap_len: got %0d want 30", n); else passed++;
    endtask

    task automatic test_enable_stall();
        int n;
        total++; if (state_a !== 3'd2) $display("FAIL stall_in_y: got %0d want 2", state_a); else passed++;
        n = 1;
        repeat (3) begin
            @(negedge clk);
            n++;
        end
        enable_a = 1'b0;
        repeat (7) begin
            @(negedge clk);
            n++;
        end
        total++; if (state_a !== 3'd2 || lights_a !== L_Y0) $display("FAIL stall_hold: got %0d/%h want 2/%h", state_a, lights_a, L_Y0); else passed++;
        enable_a = 1'b1;
        measure(1'b0, n, n);
        total++; if (n !== 17) $display("FAIL stall_y_len: got %0d want 17", n); else passed++;
        measure(1'b0, 1, n);
        total++; if (phase_a !== 2'd1 || state_a !== 3'd1) $display("FAIL stall_next: got %0d/%0d want 1/1", phase_a, state_a); else passed++;
    endtask

    task automatic test_flash();
        int n;
        repeat (5) @(negedge clk);
        flash_a = 1'b1;
        @(negedge clk);
        total++; if (state_a !== 3'd3 || lights_a !== L_FON) $display("FAIL flash_entry: got %0d/%h want 3/%h", state_a, lights_a, L_FON); else passed++;
        measure(1'b0, 1, n);
        total++; if (n !== 10) $display("FAIL flash_on_len: got %0d want 10", n); else passed++;
        total++; if (lights_a !== L_FOFF) $display("FAIL flash_dark: got %h want %h", lights_a, L_FOFF); else passed++;
        measure(1'b0, 1, n);
        total++; if (n !== 10) $display("FAIL flash_off_len: got %0d want 10", n); else passed++;
        total++; if (lights_a !== L_FON) $display("FAIL flash_reon: got %h want %h", lights_a, L_FON); else passed++;
        flash_a = 1'b0;
        @(negedge clk);
        total++; if (state_a !== 3'd0 || phase_a !== 2'd1 || lights_a !== L_RED) $display("FAIL flash_exit: got %0d/%0d/%h want 0/1/%h", state_a, phase_a, lights_a, L_RED); else passed++;
        measure(1'b0, 1, n);
        total++; if (n !== 10) $display("FAIL flash_clear_len: got %0d want 10", n); else passed++;
        total++; if (state_a !== 3'd1 || phase_a !== 2'd2) $display("FAIL flash_next: got %0d/%0d want 1/2", state_a, phase_a); else passed++;
    endtask

    task automatic test_reset_mid_green();
        int n;
        measure(1'b0, 1, n);
        measure(1'b0, 1, n);
        measure(1'b0, 1, n);
        repeat (3) @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
        total++; if (state_a !== 3'd0 || phase_a !== 2'd2 || lights_a !== L_RED) $display("FAIL midreset: got %0d/%0d/%h want 0/2/%h", state_a, phase_a, lights_a, L_RED); else passed++;
        reset_a = 1'b0;
        measure(1'b0, 1, n);
        total++; if (n !== 10 || phase_a !== 2'd0) $display("FAIL midreset_clear: got %0d/%0d want 10/0", n, phase_a); else passed++;
    endtask

    task automatic test_skip_ped();
        int n;
        reset_b = 1'b1;
        @(negedge clk);
        reset_b = 1'b0;
        measure(1'b1, 1, n);
        total++; if (phase_b !== 2'd0 || state_b !== 3'd1) $display("FAIL skip_first: got %0d/%0d want 0/1", phase_b, state_b); else passed++;
        demand_b = 3'b100;
        @(negedge clk);
        demand_b = 3'b000;
        measure(1'b1, 2, n);
        total++; if (n !== 20) $display("FAIL skip_g0_len: got %0d want 20", n); else passed++;
        total++; if (lights_b !== L_Y0PED) $display("FAIL ped_yellow: got %h want %h", lights_b, L_Y0PED); else passed++;
        measure(1'b1, 1, n);
        measure(1'b1, 1, n);
        total++; if (phase_b !== 2'd2 || lights_b !== L_G2) $display("FAIL skip_to_2: got %0d/%h want 2/%h", phase_b, lights_b, L_G2); else passed++;
        measure(1'b1, 1, n);
        total++; if (lights_b !== L_Y2) $display("FAIL ped_y2: got %h want %h", lights_b, L_Y2); else passed++;
        measure(1'b1, 1, n);
        measure(1'b1, 1, n);
        total++; if (phase_b !== 2'd0 || state_b !== 3'd1) $display("FAIL req_cleared: got %0d/%0d want 0/1", phase_b, state_b); else passed++;
    endtask

    initial begin
        reset_a  = 1'b1;
        enable_a = 1'b1;
        flash_a  = 1'b0;
        demand_a = 3'b000;
        reset_b  = 1'b1;
        enable_b = 1'b1;
        flash_b  = 1'b0;
        demand_b = 3'b000;
        @(negedge clk);
        test_reset();
        test_basic_cycle();
        test_extension();
        test_enable_stall();
        test_flash();
        test_reset_mid_green();
        test_skip_ped();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
